// File: rtl/ad_pkg.sv
// rtl/ad_pkg.sv - shared constants and sample conversion for the ADC capture path
// Purpose: default widths/ratios for ad_ctrl and the offset-binary to
//          two's-complement helper used at the default sample width.
// Optional feature macro: ADC_OTR_CNT_EN (see ad_ctrl).
package ad_pkg;

  localparam int DW_DEF      = 14;
  localparam int CLK_DIV_DEF = 4;
  localparam int OTR_CNT_W   = 16;

  // Offset binary to two's complement: inverting the MSB maps mid-scale
  // (100..0) to zero and full-scale to the most positive value.
  function automatic logic [DW_DEF-1:0] ob2tc(input logic [DW_DEF-1:0] din);
    return {~din[DW_DEF-1], din[DW_DEF-2:0]};
  endfunction

endpackage

// File: rtl/ad_clk_div.sv
// rtl/ad_clk_div.sv - ADC sample clock divider and capture-tick generator
// Purpose: divides i_clk by CLK_DIV into a registered 50% duty o_adc_clk and
//          flags the divider phase at which the input register is captured.
// Ports:
//   i_clk      in   system clock
//   i_rst_n    in   async active-low reset
//   i_en       in   enable; when low the divider parks at CLK_DIV-1
//   o_adc_clk  out  ADC sample clock, registered
//   o_tick     out  capture tick (en=1 and count==SAMPLE_PHASE), combinational
module ad_clk_div
  import ad_pkg::*;
#(
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int SAMPLE_PHASE = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_adc_clk,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] PHASE = CW'(SAMPLE_PHASE);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_adc_clk;

  // Parking at LAST while disabled makes the first enabled edge wrap to 0,
  // so adc_clk rises on the very first clk edge that samples en high.
  always_comb begin
    w_cnt_next = LAST;
    if (i_en) begin
      w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= LAST;
      r_adc_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_adc_clk <= i_en && (w_cnt_next < HALF);
    end
  end

  assign o_adc_clk = r_adc_clk;
  assign o_tick    = i_en && (r_cnt == PHASE);

endmodule

// File: rtl/ad_ctrl.sv
// rtl/ad_ctrl.sv - ADC receive controller: sample clock, capture, pipeline flush
// Purpose: drives the ADC sample clock, registers the parallel ADC word,
//          converts it to two's complement and strobes o_dout_valid once per
//          sample after discarding ADC_LATENCY pipeline samples on enable.
// Optional feature macro: ADC_OTR_CNT_EN adds a saturating over-range counter;
//          without it o_otr_cnt is tied to zero and i_otr_clr is ignored.
// Ports:
//   i_clk, i_rst_n        system clock, async active-low reset
//   i_en                  capture enable
//   i_adc_data, i_adc_otr ADC data word and out-of-range pin
//   o_adc_clk             ADC sample clock
//   o_dout, o_dout_otr    captured sample (two's complement) and over-range flag
//   o_dout_valid          one-clk strobe marking a new o_dout
//   o_otr_cnt, i_otr_clr  over-range count and its clear
module ad_ctrl
  import ad_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int CLK_DIV      = CLK_DIV_DEF,
  parameter int SAMPLE_PHASE = 2,
  parameter int ADC_LATENCY  = 7,
  parameter bit TWOS_IN      = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [DW-1:0]        i_adc_data,
  input  logic                 i_adc_otr,
  output logic                 o_adc_clk,
  output logic [DW-1:0]        o_dout,
  output logic                 o_dout_otr,
  output logic                 o_dout_valid,
  output logic [OTR_CNT_W-1:0] o_otr_cnt,
  input  logic                 i_otr_clr
);

  localparam logic [7:0] FLUSH_INIT = 8'(ADC_LATENCY);

  logic          w_tick;
  logic [DW-1:0] w_conv;
  logic [DW-1:0] r_din;
  logic          r_otr;
  logic [7:0]    r_flush;
  logic [DW-1:0] r_dout;
  logic          r_dout_otr;
  logic          r_dout_valid;

  ad_clk_div #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_clk_div (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (i_en),
    .o_adc_clk (o_adc_clk),
    .o_tick    (w_tick)
  );

  generate
    if (TWOS_IN) begin : g_conv_pass
      assign w_conv = r_din;
    end else if (DW == DW_DEF) begin : g_conv_pkg
      assign w_conv = ob2tc(r_din);
    end else begin : g_conv_msb
      assign w_conv = {~r_din[DW-1], r_din[DW-2:0]};
    end
  endgenerate

  // The input register decouples the ADC pins from the capture logic; with the
  // output register this gives a fixed two-edge pin-to-dout latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_din        <= '0;
      r_otr        <= 1'b0;
      r_flush      <= FLUSH_INIT;
      r_dout       <= '0;
      r_dout_otr   <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_din        <= i_adc_data;
      r_otr        <= i_adc_otr;
      r_dout_valid <= 1'b0;
      if (!i_en) begin
        r_flush <= FLUSH_INIT;
      end else if (w_tick) begin
        // Samples emerging during the first ADC_LATENCY periods were converted
        // before the clock was running and are dropped.
        if (r_flush != 8'd0) begin
          r_flush <= r_flush - 8'd1;
        end else begin
          r_dout       <= w_conv;
          r_dout_otr   <= r_otr;
          r_dout_valid <= 1'b1;
        end
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_otr   = r_dout_otr;
  assign o_dout_valid = r_dout_valid;

`ifdef ADC_OTR_CNT_EN
  logic [OTR_CNT_W-1:0] r_otr_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_otr_cnt <= '0;
    end else if (i_otr_clr) begin
      r_otr_cnt <= '0;
    end else if (r_dout_valid && r_dout_otr && (r_otr_cnt != '1)) begin
      r_otr_cnt <= r_otr_cnt + 1'b1;
    end
  end

  assign o_otr_cnt = r_otr_cnt;
`else
  logic w_unused_otr_clr;

  assign w_unused_otr_clr = i_otr_clr;
  assign o_otr_cnt        = '0;
`endif

endmodule
